// File: rtl/can_bit_timing_pkg.sv
// Shared definitions for the CAN bit-timing block: segment encoding,
// tq counter width and the default bit-timing constants.
package can_timing_pkg;

    // Width of the prescaler and tq-index counters.
    localparam int TQ_CNT_W = 5;

    // Segment encoding as seen on the seg output.
    typedef enum logic [1:0] {
        SEG_SYNC  = 2'd0,
        SEG_TSEG1 = 2'd1,
        SEG_TSEG2 = 2'd2
    } seg_e;

    // Default bit timing: 4 clk per tq, 1+2+3+3 = 9 tq per bit.
    localparam int DEF_BRP      = 4;
    localparam int DEF_PROP_SEG = 2;
    localparam int DEF_PHASE1   = 3;
    localparam int DEF_PHASE2   = 3;
    localparam int DEF_SJW      = 2;

endpackage

// File: rtl/can_bit_timing_if.sv
// Signal bundle between the bit-timing block and the frame layer.
// The master side (frame layer / raw pin) drives RX and bus_idle;
// the slave side (bit timer) returns timing strobes and the sampled bit.
interface can_bit_timing_if;
    logic       RX;
    logic       bus_idle;
    logic       SP;
    logic       TP;
    logic       rx_bit;
    logic       tq_tick;
    logic [1:0] seg;
    logic       phase_err;

    modport master (
        output RX, bus_idle,
        input  SP, TP, rx_bit, tq_tick, seg, phase_err
    );

    modport slave (
        input  RX, bus_idle,
        output SP, TP, rx_bit, tq_tick, seg, phase_err
    );
endinterface

// File: rtl/can_tq_prescaler.sv
// Time-quantum prescaler: divides clk by BRP, flags the last clk of each
// tq and the first clk of each tq. restart_i forces the count back to 0
// on the next clk (used for hard synchronisation).
module can_tq_prescaler
    import can_timing_pkg::*;
#(
    parameter int BRP = DEF_BRP
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    output logic tick_o,
    output logic first_o
);

    localparam logic [TQ_CNT_W-1:0] LAST = TQ_CNT_W'(BRP - 1);
    localparam logic [TQ_CNT_W-1:0] ONE  = TQ_CNT_W'(1);

    logic [TQ_CNT_W-1:0] cnt_q;
    logic [TQ_CNT_W-1:0] cnt_d;

    // Next count: wrap at BRP-1, or restart from 0 on request.
    always_comb begin
        cnt_d = cnt_q + ONE;
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o  = (cnt_q == LAST);
    assign first_o = (cnt_q == '0);

endmodule

// File: rtl/can_bit_timing.sv
// CAN bit-timing controller. Sequences every bit through SYNC, TSEG1 and
// TSEG2 in units of tq, samples the synchronised RX line at the sample
// point, and re-aligns to recessive-to-dominant edges: hard sync while the
// bus is idle, SJW-limited resync inside a frame (at most once per bit).
module can_bit_timing
    import can_timing_pkg::*;
#(
    parameter int BRP      = DEF_BRP,
    parameter int PROP_SEG = DEF_PROP_SEG,
    parameter int PHASE1   = DEF_PHASE1,
    parameter int PHASE2   = DEF_PHASE2,
    parameter int SJW      = DEF_SJW
) (
    input  logic              clk,
    input  logic              reset,
    can_bit_timing_if.slave   bt
);

    localparam int W = TQ_CNT_W;
    localparam logic [W-1:0] ONE       = W'(1);
    localparam logic [W-1:0] TSEG1_NOM = W'(PROP_SEG + PHASE1);
    localparam logic [W-1:0] PH2_W     = W'(PHASE2);
    localparam logic [W-1:0] SJW_W     = W'(SJW);

    // Synchroniser and edge-detect history.
    logic sync1_q;
    logic rx_s_q;
    logic rx_prev_q;

    // Segment state.
    seg_e         seg_q,       seg_d;
    logic [W-1:0] idx_q,       idx_d;
    logic [W-1:0] adj_q,       adj_d;
    logic [W-1:0] shrink_q,    shrink_d;
    logic         sync_done_q, sync_done_d;

    // Registered outputs.
    logic sp_q,     sp_d;
    logic rx_bit_q, rx_bit_d;
    logic perr_q,   perr_d;

    logic         tq_tick;
    logic         first_tq;
    logic         hard_sync;
    logic         rx_fall;
    logic         sync_open;
    logic [W-1:0] e_val;
    logic [W-1:0] r_val;

    can_tq_prescaler #(
        .BRP (BRP)
    ) u_presc (
        .clk       (clk),
        .reset     (reset),
        .restart_i (hard_sync),
        .tick_o    (tq_tick),
        .first_o   (first_tq)
    );

    // Two-flop synchroniser for the raw pin, plus one more stage for edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= bt.RX;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Only recessive-to-dominant transitions synchronise.
    assign rx_fall = rx_prev_q & ~rx_s_q;

    // The SP clk reopens the sync window before the edge is looked at, so an
    // edge coinciding with SP counts as TSEG2 index 0 of the current bit.
    assign sync_open = ~sync_done_q | sp_q;

    // Phase error of a late edge (TSEG1) and tq left in TSEG2 for an early one.
    assign e_val = idx_q + ONE;
    assign r_val = PH2_W - idx_q;

    // Next-state logic: SP clear, synchronisation decision, segment advance.
    always_comb begin
        seg_d       = seg_q;
        idx_d       = idx_q;
        adj_d       = adj_q;
        shrink_d    = shrink_q;
        sync_done_d = sync_done_q;
        sp_d        = 1'b0;
        rx_bit_d    = rx_bit_q;
        perr_d      = 1'b0;
        hard_sync   = 1'b0;

        if (sp_q) begin
            sync_done_d = 1'b0;
            adj_d       = '0;
            shrink_d    = '0;
        end

        if (rx_fall && sync_open) begin
            sync_done_d = 1'b1;
            if (bt.bus_idle) begin
                hard_sync = 1'b1;
            end else begin
                case (seg_q)
                    SEG_TSEG1: begin
                        if (e_val > SJW_W) begin
                            adj_d  = SJW_W;
                            perr_d = 1'b1;
                        end else begin
                            adj_d  = e_val;
                        end
                    end
                    SEG_TSEG2: begin
                        if (r_val <= SJW_W) begin
                            hard_sync = 1'b1;
                        end else begin
                            shrink_d = SJW_W;
                            perr_d   = 1'b1;
                        end
                    end
                    default: ;  // edge in SYNC: already aligned
                endcase
            end
        end

        if (hard_sync) begin
            // The edge clk itself stands in for SYNC; continue straight into TSEG1.
            seg_d    = SEG_TSEG1;
            idx_d    = '0;
            adj_d    = '0;
            shrink_d = '0;
        end else if (tq_tick) begin
            case (seg_q)
                SEG_SYNC: begin
                    seg_d = SEG_TSEG1;
                    idx_d = '0;
                end
                SEG_TSEG1: begin
                    if (e_val >= TSEG1_NOM + adj_d) begin
                        seg_d    = SEG_TSEG2;
                        idx_d    = '0;
                        sp_d     = 1'b1;
                        // sync1 becomes rx_s on this edge, so rx_bit matches
                        // rx_s during the SP clk.
                        rx_bit_d = sync1_q;
                    end else begin
                        idx_d = e_val;
                    end
                end
                SEG_TSEG2: begin
                    if (e_val >= PH2_W - shrink_d) begin
                        seg_d = SEG_SYNC;
                        idx_d = '0;
                    end else begin
                        idx_d = e_val;
                    end
                end
                default: begin
                    seg_d = SEG_SYNC;
                    idx_d = '0;
                end
            endcase
        end
    end

    // Segment FSM state and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q       <= SEG_SYNC;
            idx_q       <= '0;
            adj_q       <= '0;
            shrink_q    <= '0;
            sync_done_q <= 1'b0;
            sp_q        <= 1'b0;
            rx_bit_q    <= 1'b1;
            perr_q      <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            idx_q       <= idx_d;
            adj_q       <= adj_d;
            shrink_q    <= shrink_d;
            sync_done_q <= sync_done_d;
            sp_q        <= sp_d;
            rx_bit_q    <= rx_bit_d;
            perr_q      <= perr_d;
        end
    end

    assign bt.SP        = sp_q;
    assign bt.rx_bit    = rx_bit_q;
    assign bt.phase_err = perr_q;
    assign bt.tq_tick   = tq_tick;
    assign bt.seg       = seg_q;
    // The reset state already reads as bit start; hold TP low while reset
    // is asserted so the first TP lands in the first clk after release.
    assign bt.TP        = ~reset & (seg_q == SEG_SYNC) & first_tq;

endmodule

// File: tb/tb_can_bit_timing.sv
// Directed bench for can_bit_timing at default timing (36 clk/bit, SP at 24).
// Cycle 0 is the first clk after reset release; RX changes driven during
// cycle n reach rx_s in cycle n+2.
module tb_can_bit_timing;
    import can_timing_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    can_bit_timing_if bif();

    can_bit_timing dut (
        .clk   (clk),
        .reset (rst),
        .bt    (bif)
    );

    always #5 clk = ~clk;

    int cyc  = 0;
    int base = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    int sp_t[16];
    int rxb_t[16];
    int tp_t[16];
    int pe_t[16];
    int sp_n = 0;
    int tp_n = 0;
    int pe_n = 0;
    int seg_at[128];
    int tick_at[128];
    int mon_rel;

    // Event log, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            mon_rel = cyc - base;
            if (mon_rel >= 0 && mon_rel < 128) begin
                seg_at[mon_rel]  = int'(bif.seg);
                tick_at[mon_rel] = int'(bif.tq_tick);
            end
            if (bif.SP && sp_n < 16) begin
                sp_t[sp_n]  = mon_rel;
                rxb_t[sp_n] = int'(bif.rx_bit);
                sp_n++;
            end
            if (bif.TP && tp_n < 16) begin
                tp_t[tp_n] = mon_rel;
                tp_n++;
            end
            if (bif.phase_err && pe_n < 16) begin
                pe_t[pe_n] = mon_rel;
                pe_n++;
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    function automatic int sp_at(input int i);
        return (i < sp_n) ? sp_t[i] : -1;
    endfunction

    function automatic int rxb_at(input int i);
        return (i < sp_n) ? rxb_t[i] : -1;
    endfunction

    function automatic int tp_at(input int i);
        return (i < tp_n) ? tp_t[i] : -1;
    endfunction

    task automatic clear_logs();
        sp_n = 0;
        tp_n = 0;
        pe_n = 0;
        for (int i = 0; i < 128; i++) begin
            seg_at[i]  = -1;
            tick_at[i] = -1;
        end
    endtask

    // Reset for two clks, then release; cycle 0 starts at the last reset edge.
    task automatic start(input logic idle);
        rst          = 1'b1;
        bif.RX       = 1'b1;
        bif.bus_idle = idle;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
        clear_logs();
    endtask

    // Advance to 1 time unit after the posedge that begins cycle k.
    task automatic run_to(input int k);
        int guard;
        guard = 0;
        while ((cyc - base) < k && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_SP"},        int'(bif.SP),        0);
        check({tag, "_TP"},        int'(bif.TP),        0);
        check({tag, "_rx_bit"},    int'(bif.rx_bit),    1);
        check({tag, "_tq_tick"},   int'(bif.tq_tick),   0);
        check({tag, "_seg"},       int'(bif.seg),       0);
        check({tag, "_phase_err"}, int'(bif.phase_err), 0);
    endtask

    initial begin
        bif.RX       = 1'b1;
        bif.bus_idle = 1'b0;
        clear_logs();

        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");

        // Free run: no edges.
        start(1'b0);
        run_to(110);
        check("free_tp0", tp_at(0), 0);
        check("free_tp1", tp_at(1), 36);
        check("free_tp2", tp_at(2), 72);
        check("free_tp3", tp_at(3), 108);
        check("free_sp0", sp_at(0), 24);
        check("free_sp1", sp_at(1), 60);
        check("free_sp2", sp_at(2), 96);
        check("free_rxb", rxb_at(1), 1);
        check("free_pe",  pe_n, 0);
        check("free_tick2", tick_at[2], 0);
        check("free_tick3", tick_at[3], 1);
        check("free_seg3",  seg_at[3], 0);
        check("free_seg4",  seg_at[4], 1);
        check("free_seg23", seg_at[23], 1);
        check("free_seg24", seg_at[24], 2);
        check("free_seg36", seg_at[36], 0);

        // Hard sync: idle bus, edge reaches rx_s at 52.
        start(1'b1);
        run_to(50);
        bif.RX = 1'b0;
        run_to(100);
        check("hard_sp0", sp_at(0), 24);
        check("hard_sp1", sp_at(1), 73);
        check("hard_rxb", rxb_at(1), 0);
        check("hard_tp2", tp_at(2), 85);
        check("hard_pe",  pe_n, 0);

        // Late edge, e=2: TSEG1 lengthened by 2 tq.
        start(1'b0);
        run_to(6);
        bif.RX = 1'b0;
        run_to(80);
        check("late_sp0", sp_at(0), 32);
        check("late_rxb", rxb_at(0), 0);
        check("late_tp1", tp_at(1), 44);
        check("late_sp1", sp_at(1), 68);
        check("late_pe",  pe_n, 0);

        // Large late edge, e=5: clamped to SJW, one phase error.
        start(1'b0);
        run_to(18);
        bif.RX = 1'b0;
        run_to(80);
        check("large_sp0", sp_at(0), 32);
        check("large_sp1", sp_at(1), 68);
        check("large_pe_n", pe_n, 1);
        check("large_pe_at", int'(pe_n > 0 && pe_t[0] >= 20 && pe_t[0] <= 21), 1);

        // Early edge with r=1: behaves as hard sync.
        start(1'b0);
        run_to(31);
        bif.RX = 1'b0;
        run_to(80);
        check("early1_sp0", sp_at(0), 24);
        check("early1_sp1", sp_at(1), 54);
        check("early1_tp1", tp_at(1), 66);
        check("early1_pe",  pe_n, 0);

        // Early edge with r=3: TSEG2 shortened by SJW, phase error.
        start(1'b0);
        run_to(23);
        bif.RX = 1'b0;
        run_to(70);
        check("early3_tp1", tp_at(1), 28);
        check("early3_sp1", sp_at(1), 52);
        check("early3_pe",  pe_n, 1);

        // Two edges in one bit: the second is ignored.
        start(1'b0);
        run_to(6);
        bif.RX = 1'b0;
        run_to(10);
        bif.RX = 1'b1;
        run_to(14);
        bif.RX = 1'b0;
        run_to(60);
        check("dbl_sp0", sp_at(0), 32);
        check("dbl_tp1", tp_at(1), 44);
        check("dbl_pe",  pe_n, 0);

        // Edge landing on the SP clk after an earlier sync in the same bit.
        start(1'b0);
        run_to(6);
        bif.RX = 1'b0;
        run_to(12);
        bif.RX = 1'b1;
        run_to(30);
        bif.RX = 1'b0;
        run_to(70);
        check("spedge_sp0", sp_at(0), 32);
        check("spedge_rxb", rxb_at(0), 0);
        check("spedge_tp1", tp_at(1), 36);
        check("spedge_sp1", sp_at(1), 60);
        check("spedge_pe",  pe_n, 1);

        // Reset asserted mid-TSEG1 after rx_bit has gone to 0.
        start(1'b0);
        run_to(6);
        bif.RX = 1'b0;
        run_to(50);
        check("mid_seg_before", int'(bif.seg), 1);
        rst    = 1'b1;
        bif.RX = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
        clear_logs();
        @(negedge clk);
        check("midrst_first_tp", int'(bif.TP), 1);
        run_to(40);
        check("midrst_sp0", sp_at(0), 24);
        check("midrst_rxb", rxb_at(0), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/can_bit_timing.md
Name: can_bit_timing

Overview:
- Bit-timing controller that drives the CAN frame maker chain with its SP (sample point) and RX bit stream.
- Divides the system clock into time quanta (tq) and sequences each bit through SYNC, TSEG1 and TSEG2.
- Performs hard synchronisation while the bus is idle and SJW-limited resynchronisation during a frame.
- Sits between the raw RX pin and the frame makers / error block, and is their only source of SP.

Parameters:
- BRP, 4: clk cycles per tq (2..16).
- PROP_SEG, 2: propagation segment in tq (1..8).
- PHASE1, 3: phase segment 1 in tq (1..8).
- PHASE2, 3: phase segment 2 in tq (2..8).
- SJW, 2: resync jump width in tq (1..4, ≤ PHASE1, ≤ PHASE2).

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high.
- RX  in  1  raw bus input; 1 = recessive, 0 = dominant.
- bus_idle  in  1  from frame layer; high during idle or intermission, selects hard sync.
- SP  out  1  one-clk pulse at the sample point.
- TP  out  1  one-clk pulse at bit start (first clk of SYNC); transmit point.
- rx_bit  out  1  RX value sampled at SP; valid and updated in the same cycle SP is high.
- tq_tick  out  1  one-clk pulse at the last clk of every tq.
- seg  out  2  current segment: 0 = SYNC, 1 = TSEG1, 2 = TSEG2.
- phase_err  out  1  one-clk pulse when a resync edge has |e| > SJW.

Behaviour:
- Reset values: SP=0, TP=0, rx_bit=1, tq_tick=0, seg=SYNC, phase_err=0; prescaler=0, tq counter=0, sync_done=0, synchroniser flops=1.
- Reset takes effect on the next clk edge, including mid-bit. First TP occurs in the first clk after reset deasserts.
- RX passes through a 2-flop synchroniser to give rx_s. An edge is rx_s going 1→0 (recessive→dominant) only.
- Prescaler counts 0..BRP-1. tq_tick is high when it equals BRP-1.
- Segment sequencing, advancing on tq_tick:
  - SYNC: 1 tq.
  - TSEG1: PROP_SEG+PHASE1+adj tq.
  - TSEG2: PHASE2−shrink tq.
- Nominal bit = BRP·(1+PROP_SEG+PHASE1+PHASE2) clk, i.e. 36 clk at defaults.
- SP fires in the first clk of TSEG2. At that clk, rx_bit ← rx_s. SP offset from TP = BRP·(1+PROP_SEG+PHASE1) = 24 clk at defaults.
- At SP: clear sync_done, adj and shrink.
- At most one synchronisation between consecutive SPs. An edge while sync_done=1 is ignored.
- Hard sync (edge, bus_idle=1, sync_done=0):
  - Next clk: prescaler=0, seg=TSEG1, tq index=0, adj=0, sync_done=1.
  - The edge clk counts as SYNC. TP is not pulsed.
- Resync (edge, bus_idle=0, sync_done=0), with idx = current tq index in the segment:
  - In SYNC: e=0. No action, but set sync_done.
  - In TSEG1: e=idx+1. adj=min(e,SJW). phase_err if e>SJW.
  - In TSEG2: r=PHASE2−idx (remaining tq, including the current one).
    - If r ≤ SJW: act exactly as a hard sync.
    - Else: shrink=SJW and pulse phase_err.
- Edge and reset in the same cycle: reset wins.
- Edge in the same clk as the SP pulse: processed after the SP clear, so it is in TSEG2 idx 0.
- Counters are 5-bit. The TSEG1 limit is PROP_SEG+PHASE1+adj ≤ 20, so no wrap.

Decomposition:
- Package can_timing_pkg holds:
  - the seg encoding constants (SEG_SYNC, SEG_TSEG1, SEG_TSEG2);
  - the tq counter width (5);
  - the default segment constants.
- One sub-module, can_tq_prescaler: prescaler with a synchronous restart input, producing tq_tick.
- Segment FSM, synchroniser and resync logic stay in can_bit_timing.

Test Plan:
- Free-run: RX=1, bus_idle=0 from reset release → TP at cycles 0, 36, 72…; SP at 24, 60, 96…; rx_bit=1.
- Hard sync: bus_idle=1, RX 1→0 at cycle 50 (rx_s falls at 52) → SP at cycle 52+1+BRP·(PROP_SEG+PHASE1)=73; rx_bit=0; no phase_err.
- Late edge: bus_idle=0, rx_s falls in TSEG1 idx 1 (e=2) → bit lengthened by 2 tq; SP 8 clk later than nominal; then nominal spacing.
- Large late edge: e=5 in TSEG1 → adj=2 (SJW); phase_err single pulse; SP 8 clk late.
- Early edge: falls in TSEG2 idx 2 (r=1 ≤ SJW) → behaves as hard sync; next SP at edge+1+20 clk. Falls at TSEG2 idx 0 (r=3) → TSEG2 shortened 2 tq; phase_err pulse.
- Double edge and reset: two edges within one bit → second ignored. Reset asserted mid-TSEG1 → next clk all outputs at reset values; first TP one clk after reset release.
